module_tx_arbiter_uart: RTL and testbench
=========================================

# module_tx_arbiter_uart

Round-robin arbiter and sequencer that shares the single UART transmitter (UART_TX_CTRL) between two byte sources: the processor's data-register path and the keyboard scan path. It accepts one byte per grant from the winning requester and drives the transmitter's SEND/DATA pair. It then tracks READY through the busy/done cycle before accepting the next byte. It sits between the requesters and UART_TX_CTRL, replacing direct control of SEND.

## Interface
- WAIT_LIMIT, 16: max cycles in WAIT_BUSY for ready_i to fall after a send pulse; range 2..255.
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- req0_i  in  1  source 0 (processor) request; hold until gnt0_o
- data0_i  in  8  source 0 byte; stable while req0_i high
- gnt0_o  out  1  one-cycle pulse, source 0 byte accepted
- req1_i  in  1  source 1 (keyboard) request; hold until gnt1_o
- data1_i  in  8  source 1 byte; stable while req1_i high
- gnt1_o  out  1  one-cycle pulse, source 1 byte accepted
- ready_i  in  1  READY from UART_TX_CTRL
- send_o  out  1  SEND to UART_TX_CTRL, one-cycle pulse
- data_o  out  8  DATA to UART_TX_CTRL, registered
- busy_o  out  1  high whenever state ≠ IDLE
- last_src_o  out  1  source of most recent grant (0/1)
- err_o  out  1  sticky: ready_i never fell after a send

## Operation
- Reset values: state IDLE, send_o 0, gnt0_o 0, gnt1_o 0, data_o 8'h00, busy_o 0, last_src_o 1 (source 0 wins the first tie), err_o 0, wait counter 0.
- IDLE: if ready_i=1 and (req0_i|req1_i), arbitrate, latch the winner's byte into data_o, set last_src_o, go to SEND. Otherwise stay. Requests while ready_i=0 are not served.
- Arbitration: only one source requesting → it wins. Both requesting → the source ≠ last_src_o wins (strict alternation under contention).
- SEND (1 cycle): send_o=1. The winner's gnt pulses this same cycle. Clear the wait counter. Go to WAIT_BUSY.
- WAIT_BUSY: ready_i=0 → WAIT_DONE. Otherwise increment the counter. When the counter reaches WAIT_LIMIT with ready_i still 1, set err_o and go to IDLE. No retry; the byte is dropped.
- WAIT_DONE: stay while ready_i=0. ready_i=1 → IDLE.
- data_o holds its value from the grant until the next grant. It never changes in WAIT_BUSY or WAIT_DONE.
- err_o clears only on rst_i.
- Requester rule: drop req in the cycle after gnt, or a new transaction starts with the same data. The arbiter does not check this.

## Timing
- Outputs are Moore and registered. send_o, gnt*_o and data_o change on the edge following the IDLE sample.
- Request sampled in IDLE at edge n → cycle n+1: send_o=1, gnt=1, data_o valid, busy_o=1. Latency is 1 cycle.
- busy_o falls on the edge after ready_i returns high in WAIT_DONE. The earliest next grant comes one cycle after IDLE is re-entered.
- Minimum spacing between grants is 4 cycles plus the UART frame time (ready_i low period).
- Simultaneous req0_i/req1_i rise: resolved in the same cycle by last_src_o. The loser keeps its req and is served next.
- rst_i in any state (including mid-frame WAIT_DONE): next edge gives reset values. The transmitter finishes its frame independently. A new grant requires ready_i=1.
- WAIT_BUSY timeout: err_o rises on the edge where the count reaches WAIT_LIMIT. busy_o falls on the same edge.

## Test plan
- Single request: req0_i=1, data0_i=8'h41, ready_i=1 → next cycle send_o=1, gnt0_o=1, data_o=8'h41. Model drops ready_i for 100 cycles → busy_o falls 1 cycle after ready_i rises.
- Contention: req0_i and req1_i held high with 8'hA5/8'h3C over 4 transactions → data_o sequence A5,3C,A5,3C; last_src_o toggles 0,1,0,1.
- Blocked IDLE: ready_i=0 at reset release, req1_i=1 → no send_o, no gnt1_o. Raise ready_i → grant on the next edge.
- Timeout: ready_i stuck 1 after send with WAIT_LIMIT=16 → err_o=1 exactly 16 cycles after the send cycle, state IDLE. err_o stays 1 through later transfers.
- Reset mid-frame: assert rst_i for 1 cycle in WAIT_DONE → all outputs at reset values, last_src_o=1, err_o=0. The next tie goes to source 0.
- Late request: req1_i raised while busy in WAIT_DONE → held, granted 1 cycle after return to IDLE, data_o unchanged until then.

Source files
------------

// File: rtl/module_tx_arbiter_uart.sv
// Round-robin share of one UART transmitter between two byte sources; request sampled in IDLE
// gives send/grant/data one cycle later; requests wait (no grant) while ready_i is low or a frame is in flight.
module module_tx_arbiter_uart #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_i,
    input  logic [7:0] data0_i,
    output logic       gnt0_o,
    input  logic       req1_i,
    input  logic [7:0] data1_i,
    output logic       gnt1_o,
    input  logic       ready_i,
    output logic       send_o,
    output logic [7:0] data_o,
    output logic       busy_o,
    output logic       last_src_o,
    output logic       err_o
);

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t     state_q, state_d;
    logic       send_q, send_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       last_src_q, last_src_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pick1;

    // Under contention the source that did not win last time goes next.
    assign pick1 = req1_i & (~req0_i | ~last_src_q);

    always_comb begin
        state_d    = state_q;
        send_d     = 1'b0;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        data_d     = data_q;
        last_src_d = last_src_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (ready_i && (req0_i || req1_i)) begin
                    state_d    = ST_SEND;
                    send_d     = 1'b1;
                    gnt0_d     = ~pick1;
                    gnt1_d     = pick1;
                    data_d     = pick1 ? data1_i : data0_i;
                    last_src_d = pick1;
                    cnt_d      = 8'd0;
                end
            end
            ST_SEND: begin
                // The counter measures cycles since the send pulse, so the SEND cycle counts.
                cnt_d   = 8'd1;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!ready_i) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            send_q     <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            data_q     <= 8'h00;
            busy_q     <= 1'b0;
            last_src_q <= 1'b1;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            send_q     <= send_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            last_src_q <= last_src_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign send_o     = send_q;
    assign gnt0_o     = gnt0_q;
    assign gnt1_o     = gnt1_q;
    assign data_o     = data_q;
    assign busy_o     = busy_q;
    assign last_src_o = last_src_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_module_tx_arbiter_uart.sv
// Directed bench for the UART transmit arbiter: hand-computed expectations, checked 1 time unit after each edge.
module tb_module_tx_arbiter_uart;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req0_i, req1_i, ready_i;
    logic [7:0] data0_i, data1_i;
    logic       gnt0_o, gnt1_o, send_o, busy_o, last_src_o, err_o;
    logic [7:0] data_o;

    int n_checks = 0;
    int n_fail   = 0;

    module_tx_arbiter_uart #(.WAIT_LIMIT(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req0_i     (req0_i),
        .data0_i    (data0_i),
        .gnt0_o     (gnt0_o),
        .req1_i     (req1_i),
        .data1_i    (data1_i),
        .gnt1_o     (gnt1_o),
        .ready_i    (ready_i),
        .send_o     (send_o),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .last_src_o (last_src_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Snapshot of the externally visible outputs: {send, gnt0, gnt1, busy, last_src, err, data}
    function automatic logic [13:0] outs();
        return {send_o, gnt0_o, gnt1_o, busy_o, last_src_o, err_o, data_o};
    endfunction

    logic [7:0] exp_dat [4];
    logic       exp_src [4];

    initial begin
        rst_i   = 1'b1;
        req0_i  = 1'b0;
        req1_i  = 1'b0;
        data0_i = 8'h00;
        data1_i = 8'h00;
        ready_i = 1'b1;
        step();
        step();
        check_eq("reset_outs", outs(), {6'b000010, 8'h00});
        rst_i = 1'b0;

        // Single request from source 0, then a late source-1 request during the frame
        req0_i  = 1'b1;
        data0_i = 8'h41;
        step();
        check_eq("single_grant", outs(), {6'b110100, 8'h41});
        req0_i  = 1'b0;
        ready_i = 1'b0;
        step();
        check_eq("wait_busy_send_low", {send_o, gnt0_o, busy_o}, 3'b001);
        step();
        req1_i  = 1'b1;
        data1_i = 8'h77;
        for (int i = 0; i < 98; i++) step();
        check_eq("late_req_held", {gnt1_o, send_o, busy_o, data_o}, {3'b001, 8'h41});
        ready_i = 1'b1;
        step();
        check_eq("busy_fall", {busy_o, gnt1_o, data_o}, {2'b00, 8'h41});
        step();
        check_eq("late_req_grant", outs(), {6'b101110, 8'h77});
        req1_i  = 1'b0;
        ready_i = 1'b0;
        step();
        step();
        ready_i = 1'b1;
        step();
        check_eq("frame2_done", busy_o, 1'b0);

        // Timeout: ready_i never falls after the send pulse
        req0_i  = 1'b1;
        data0_i = 8'h55;
        step();
        check_eq("to_grant", outs(), {6'b110100, 8'h55});
        req0_i = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check_eq("to_before", {err_o, busy_o}, 2'b01);
        step();
        check_eq("to_err", {err_o, busy_o, send_o}, 3'b100);

        // err_o stays set across a later good transfer
        req1_i  = 1'b1;
        data1_i = 8'h99;
        step();
        check_eq("post_err_grant", outs(), {6'b101111, 8'h99});
        req1_i  = 1'b0;
        ready_i = 1'b0;
        step();
        step();
        check_eq("err_sticky", {err_o, busy_o}, 2'b11);

        // Reset while in WAIT_DONE; transmitter keeps ready_i low for the rest of its frame
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_eq("midframe_reset", outs(), {6'b000010, 8'h00});

        // Blocked IDLE with both sources requesting, then strict alternation
        req0_i  = 1'b1;
        req1_i  = 1'b1;
        data0_i = 8'hA5;
        data1_i = 8'h3C;
        step();
        step();
        step();
        check_eq("blocked_idle", {send_o, gnt0_o, gnt1_o, busy_o}, 4'b0000);
        exp_dat = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
        ready_i = 1'b1;
        step();
        for (int t = 0; t < 4; t++) begin
            check_eq($sformatf("cont_grant%0d", t),
                     {send_o, gnt0_o, gnt1_o, last_src_o, data_o},
                     {1'b1, ~exp_src[t], exp_src[t], exp_src[t], exp_dat[t]});
            if (t == 3) begin
                req0_i = 1'b0;
                req1_i = 1'b0;
            end
            ready_i = 1'b0;
            step();
            step();
            step();
            check_eq($sformatf("cont_hold%0d", t), {busy_o, data_o}, {1'b1, exp_dat[t]});
            ready_i = 1'b1;
            step();
            check_eq($sformatf("cont_idle%0d", t), {busy_o, send_o}, 2'b00);
            step();
        end
        check_eq("final_idle", {send_o, busy_o, err_o}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
